// File: rtl/frame_receiver.sv
// Byte-link receive endpoint: finds A5/LEN/payload/CHK frames, forwards payload through a FIFO.
// Optional saturating error counter on port err_count when FRAME_RX_ERRCNT_EN is defined.
module frame_receiver #(
    parameter int DEPTH   = 4,
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err
`ifdef FRAME_RX_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [7:0]  cnt_r, cnt_next_s;
    logic [7:0]  chk_r, chk_next_s;
    logic        push_s, last_s, ok_s, err_s, pop_s, accept_s, full_s, empty_s;
    logic [8:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign in_ready  = (state_r != ST_PAYLOAD) || !full_s;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = !empty_s;
    assign pop_s     = out_valid && out_ready;
    assign out_data  = mem_r[rd_ptr_r[AW-1:0]][7:0];
    assign out_last  = mem_r[rd_ptr_r[AW-1:0]][8];

    // Next-state, counter, checksum and status decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        chk_next_s   = chk_r;
        push_s       = 1'b0;
        last_s       = 1'b0;
        ok_s         = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (accept_s && (in_data == SYNC_BYTE)) begin
                    state_next_s = ST_LEN;
                end else begin
                    state_next_s = ST_HUNT;
                end
            end
            ST_LEN: begin
                if (!accept_s) begin
                    state_next_s = ST_LEN;
                end else if ((in_data == 8'h00) || (in_data > MAX_LEN_B)) begin
                    err_s        = 1'b1;
                    state_next_s = ST_HUNT;
                end else begin
                    cnt_next_s   = in_data;
                    chk_next_s   = 8'h00;
                    state_next_s = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    push_s     = 1'b1;
                    chk_next_s = chk_r ^ in_data;
                    cnt_next_s = cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        last_s       = 1'b1;
                        state_next_s = ST_CHECK;
                    end else begin
                        state_next_s = ST_PAYLOAD;
                    end
                end else begin
                    state_next_s = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    ok_s         = (in_data == chk_r);
                    err_s        = (in_data != chk_r);
                    state_next_s = ST_HUNT;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            default: begin
                state_next_s = ST_HUNT;
            end
        endcase
    end

    // FSM state, length counter, checksum and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_HUNT;
            cnt_r     <= 8'h00;
            chk_r     <= 8'h00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            chk_r     <= chk_next_s;
            frame_ok  <= ok_s;
            frame_err <= err_s;
        end
    end

    // Payload FIFO storage and pointers; reset also clears entries so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {last_s, in_data};
                wr_ptr_r                <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

`ifdef FRAME_RX_ERRCNT_EN
    // Saturating count of error pulses, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'h00;
        end else if (err_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end else begin
            err_count <= err_count;
        end
    end
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// Directed self-checking bench for frame_receiver (DEPTH=4, MAX_LEN=16).
// Error-counter checks are included when FRAME_RX_ERRCNT_EN is defined.
module tb_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
`ifdef FRAME_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    int ok_seen = 0;
    int err_seen = 0;
    logic [8:0] outq [$];

    frame_receiver #(.DEPTH(4), .MAX_LEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
`ifdef FRAME_RX_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Record popped bytes and status pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) outq.push_back({out_last, out_data});
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [8:0] e);
        logic [8:0] got;
        got = 9'h1FF;
        chk({tag, "_present"}, 32'(outq.size() > 0), 32'd1);
        if (outq.size() > 0) got = outq.pop_front();
        chk(tag, 32'(got), 32'(e));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_frame_ok",  32'(frame_ok),  32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
`ifdef FRAME_RX_ERRCNT_EN
        chk("rst_err_count", 32'(err_count), 32'h00);
`endif
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Good frame A5 03 11 22 33 00
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data",  32'(out_data),  32'h11);
        send(8'h22);
        send(8'h33);
        send(8'h00);
        chk("ok_pulse_hi", 32'(frame_ok), 32'd1);
        idle(1);
        chk("ok_pulse_lo", 32'(frame_ok), 32'd0);
        idle(3);
        expect_out("f1_b0", 9'h011);
        expect_out("f1_b1", 9'h022);
        expect_out("f1_b2", 9'h133);
        chk("f1_ok",  32'(ok_seen),  32'd1);
        chk("f1_err", 32'(err_seen), 32'd0);

        // Bad checksum A5 02 0F F0 00 (expected FF)
        send(8'hA5);
        send(8'h02);
        send(8'h0F);
        send(8'hF0);
        send(8'h00);
        chk("err_pulse_hi", 32'(frame_err), 32'd1);
        idle(3);
        expect_out("f2_b0", 9'h00F);
        expect_out("f2_b1", 9'h1F0);
        chk("f2_ok",  32'(ok_seen),  32'd1);
        chk("f2_err", 32'(err_seen), 32'd1);
`ifdef FRAME_RX_ERRCNT_EN
        chk("f2_err_count", 32'(err_count), 32'd1);
`endif

        // Bad lengths 0 and 17, then junk, then A5 01 7E 7E
        send(8'hA5);
        send(8'h00);
        chk("len0_err", 32'(frame_err), 32'd1);
        send(8'hA5);
        send(8'h11);
        chk("len17_err", 32'(frame_err), 32'd1);
        idle(2);
        chk("badlen_nopush", 32'(outq.size()), 32'd0);
        chk("badlen_errs",   32'(err_seen),    32'd3);
        send(8'h00);
        send(8'h12);
        send(8'hA5);
        send(8'h01);
        send(8'h7E);
        send(8'h7E);
        idle(3);
        expect_out("f3_b0", 9'h17E);
        chk("f3_ok",  32'(ok_seen),  32'd2);
        chk("f3_err", 32'(err_seen), 32'd3);
`ifdef FRAME_RX_ERRCNT_EN
        chk("f3_err_count", 32'(err_count), 32'd3);
`endif

        // Backpressure: LEN 6 with out_ready low, FIFO fills after 4 pushes
        out_ready = 1'b0;
        send(8'hA5);
        send(8'h06);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        chk("full_in_ready",  32'(in_ready),  32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head",      32'(out_data),  32'h01);
        in_valid = 1'b1;
        in_data  = 8'h05;
        idle(3);
        chk("full_hold_ready", 32'(in_ready),    32'd0);
        chk("full_no_pop",     32'(outq.size()), 32'd0);
        out_ready = 1'b1;
        send(8'h05);
        send(8'h06);
        send(8'h07);
        idle(6);
        expect_out("f4_b0", 9'h001);
        expect_out("f4_b1", 9'h002);
        expect_out("f4_b2", 9'h003);
        expect_out("f4_b3", 9'h004);
        expect_out("f4_b4", 9'h005);
        expect_out("f4_b5", 9'h106);
        chk("f4_ok",  32'(ok_seen),  32'd3);
        chk("f4_err", 32'(err_seen), 32'd3);

        // Reset during the third payload byte
        out_ready = 1'b0;
        send(8'hA5);
        send(8'h03);
        send(8'hAA);
        send(8'hBB);
        in_valid = 1'b1;
        in_data  = 8'hCC;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        idle(1);
        chk("mid_rst_out_valid2", 32'(out_valid), 32'd0);
        chk("mid_rst_ok",         32'(frame_ok),  32'd0);
        chk("mid_rst_err",        32'(frame_err), 32'd0);
        chk("mid_rst_in_ready",   32'(in_ready),  32'd1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(1);
        out_ready = 1'b1;
        send(8'hA5);
        send(8'h01);
        send(8'h5A);
        send(8'h5A);
        idle(3);
        expect_out("f5_b0", 9'h15A);
        chk("f5_outq_empty", 32'(outq.size()), 32'd0);
        chk("f5_ok",  32'(ok_seen),  32'd4);
        chk("f5_err", 32'(err_seen), 32'd3);

`ifdef FRAME_RX_ERRCNT_EN
        // The reset above cleared the counter; drive enough bad frames to saturate it
        chk("rst_cleared_err_count", 32'(err_count), 32'd0);
        for (int k = 0; k < 260; k++) begin
            send(8'hA5);
            send(8'h00);
        end
        idle(2);
        chk("sat_err_count", 32'(err_count), 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
